chroma_ds_scheduler: RTL and testbench
======================================

CHROMA_DS_SCHEDULER -- requirements
Module: chroma_ds_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64: maximum RUN-state cycles allowed before ds_done is required.
REQ-002 The block SHALL have port Clock  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  an 8x8 Cb/Cr block is offered.
REQ-005 The block SHALL have port in_ready  output  1  the scheduler accepts a block this cycle.
REQ-006 The block SHALL have ports in_Cb, in_Cr  input  512 each  64 pixels of 8 bits; pixel (r,c) at bits [(r*8+c)*8 +: 8].
REQ-007 The block SHALL have port ds_clear  output  1  one-cycle clear pulse to the downsampler reset.
REQ-008 The block SHALL have port ds_enable  output  1  downsampler enable.
REQ-009 The block SHALL have ports ds_Cb, ds_Cr  output  512 each  block data driven to the downsampler.
REQ-010 The block SHALL have port ds_done  input  1  downsampler result valid.
REQ-011 The block SHALL have ports ds_Cb_d, ds_Cr_d  input  512 each  downsampled result.
REQ-012 The block SHALL have port out_valid  output  1  result available.
REQ-013 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-014 The block SHALL have ports out_Cb, out_Cr  output  512 each  registered result.
REQ-015 The block SHALL have port blk_count  output  16  number of blocks delivered.
REQ-016 The block SHALL have port timeout_err  output  1  sticky watchdog flag.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, RUN and OUT, and all outputs SHALL be registered or decoded from the state register only.
REQ-018 In IDLE, in_ready SHALL be 1. On in_valid=1 the FSM SHALL latch in_Cb/in_Cr into ds_Cb/ds_Cr and go to CLEAR; in_ready SHALL be 0 in every other state.
REQ-019 In CLEAR, ds_clear SHALL be 1 for exactly one cycle, ds_enable SHALL be 0, and the next state SHALL be RUN.
REQ-020 In RUN, ds_enable SHALL be 1 and the 7-bit watchdog SHALL increment each cycle from 0; ds_clear SHALL be 0.
REQ-021 When ds_done=1 is sampled in RUN, the block SHALL capture ds_Cb_d/ds_Cr_d into out_Cb/out_Cr, set out_valid=1, drop ds_enable and go to OUT on the same edge.
REQ-022 If the watchdog reaches TIMEOUT-1 in RUN with ds_done=0, the block SHALL set timeout_err=1, drop ds_enable, discard the block, leave blk_count and out_valid unchanged, and go to IDLE.
REQ-023 When ds_done=1 coincides with the watchdog reaching TIMEOUT-1, done SHALL win and no timeout SHALL be flagged.
REQ-024 In OUT, out_valid, out_Cb and out_Cr SHALL stay stable until out_valid and out_ready are both 1. On that edge out_valid SHALL go 0, blk_count SHALL increment (wrapping 16'hFFFF to 0), and the FSM SHALL go to IDLE.
REQ-025 ds_done SHALL be ignored outside RUN; in_valid SHALL be ignored outside IDLE.
REQ-026 Throughput SHALL be one block per (1 accept + 1 clear + RUN cycles + 1 OUT handshake) cycles, with no overlap of blocks.
REQ-027 timeout_err SHALL clear only on reset.

Reset
REQ-028 On reset=1, asynchronously: state IDLE; in_ready=1; ds_clear=0; ds_enable=0; ds_Cb, ds_Cr, out_Cb and out_Cr all 0; out_valid=0; blk_count=0; timeout_err=0; watchdog=0.
REQ-029 Reset asserted mid-RUN or mid-OUT SHALL abort the block with no output and no count.

Verification
REQ-030 Single block, Cb all 8'h10, Cr all 8'h80, with a downsampler model giving done after 18 cycles -> one ds_clear pulse, out_Cb all 8'h10, out_Cr all 8'h80, blk_count=1.
REQ-031 Cb block 2x2 quad {8'd1, 8'd2, 8'd3, 8'd4} repeated -> out_Cb every pixel 8'd2; out_Cr checked likewise.
REQ-032 out_ready held 0 for 10 cycles -> out_valid and out data stable, in_ready=0, and a second in_valid is not accepted until the handshake completes.
REQ-033 ds_done never asserted, TIMEOUT=64 -> timeout_err=1 after 64 RUN cycles, return to IDLE, blk_count unchanged, next block processed normally.
REQ-034 reset pulsed during RUN -> all outputs at REQ-028 values immediately, with no out_valid.
REQ-035 blk_count preloaded by 65535 handshakes (or forced) and one more block -> blk_count=0.

Source files
------------

// File: rtl/chroma_ds_scheduler_if.sv
// rtl/chroma_ds_scheduler_if.sv - handshake/data bundle between scheduler, source, downsampler and sink
//
// Purpose: groups every stream and downsampler signal of chroma_ds_scheduler.
// Signals:
//   in_valid/in_ready, in_Cb/in_Cr        : 8x8 block offered by the source
//   ds_clear/ds_enable, ds_Cb/ds_Cr       : control and block data to the downsampler
//   ds_done, ds_Cb_d/ds_Cr_d              : downsampler result
//   out_valid/out_ready, out_Cb/out_Cr    : registered result towards the consumer
// Modports: slave = scheduler view, master = environment view.
interface chroma_ds_scheduler_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_Cb;
  logic [511:0] in_Cr;
  logic         ds_clear;
  logic         ds_enable;
  logic [511:0] ds_Cb;
  logic [511:0] ds_Cr;
  logic         ds_done;
  logic [511:0] ds_Cb_d;
  logic [511:0] ds_Cr_d;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_Cb;
  logic [511:0] out_Cr;

  modport slave (
    input  in_valid, in_Cb, in_Cr, ds_done, ds_Cb_d, ds_Cr_d, out_ready,
    output in_ready, ds_clear, ds_enable, ds_Cb, ds_Cr, out_valid, out_Cb, out_Cr
  );

  modport master (
    output in_valid, in_Cb, in_Cr, ds_done, ds_Cb_d, ds_Cr_d, out_ready,
    input  in_ready, ds_clear, ds_enable, ds_Cb, ds_Cr, out_valid, out_Cb, out_Cr
  );
endinterface

// File: rtl/chroma_ds_scheduler.sv
// rtl/chroma_ds_scheduler.sv - sequences one 8x8 Cb/Cr block at a time through an external downsampler
//
// Purpose: accepts a block, pulses the downsampler clear, enables it until it
// reports done (or a watchdog expires), then holds the result until the
// consumer takes it.
// Ports:
//   Clock       : rising-edge clock
//   reset       : asynchronous, active-high reset
//   bus         : chroma_ds_scheduler_if.slave (input stream, downsampler, output stream)
//   blk_count   : number of blocks delivered to the consumer (wraps)
//   timeout_err : sticky watchdog flag, cleared only by reset
module chroma_ds_scheduler #(
  parameter int TIMEOUT = 64
) (
  input  logic                   Clock,
  input  logic                   reset,
  chroma_ds_scheduler_if.slave   bus,
  output logic [15:0]            blk_count,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, OUT} state_t;

  // Last watchdog value allowed in RUN; TIMEOUT RUN cycles in total.
  localparam logic [6:0] WD_LAST = 7'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [6:0]   wd_q, wd_d;
  logic [511:0] ds_cb_q, ds_cb_d;
  logic [511:0] ds_cr_q, ds_cr_d;
  logic [511:0] out_cb_q, out_cb_d;
  logic [511:0] out_cr_q, out_cr_d;
  logic         out_valid_q, out_valid_d;
  logic [15:0]  blk_count_q, blk_count_d;
  logic         timeout_err_q, timeout_err_d;

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      ds_cb_q       <= '0;
      ds_cr_q       <= '0;
      out_cb_q      <= '0;
      out_cr_q      <= '0;
      out_valid_q   <= 1'b0;
      blk_count_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      ds_cb_q       <= ds_cb_d;
      ds_cr_q       <= ds_cr_d;
      out_cb_q      <= out_cb_d;
      out_cr_q      <= out_cr_d;
      out_valid_q   <= out_valid_d;
      blk_count_q   <= blk_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    ds_cb_d       = ds_cb_q;
    ds_cr_d       = ds_cr_q;
    out_cb_d      = out_cb_q;
    out_cr_d      = out_cr_q;
    out_valid_d   = out_valid_q;
    blk_count_d   = blk_count_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          ds_cb_d = bus.in_Cb;
          ds_cr_d = bus.in_Cr;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        wd_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        // done is checked first so it wins over a coincident watchdog expiry
        if (bus.ds_done) begin
          out_cb_d    = bus.ds_Cb_d;
          out_cr_d    = bus.ds_Cr_d;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else if (wd_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          wd_d          = '0;
          state_d       = IDLE;
        end else begin
          wd_d = wd_q + 7'd1;
        end
      end
      OUT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          blk_count_d = blk_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control strobes are pure decodes of the state register.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.ds_clear  = (state_q == CLEAR);
  assign bus.ds_enable = (state_q == RUN);
  assign bus.ds_Cb     = ds_cb_q;
  assign bus.ds_Cr     = ds_cr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_Cb    = out_cb_q;
  assign bus.out_Cr    = out_cr_q;
  assign blk_count     = blk_count_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_chroma_ds_scheduler.sv
// tb/tb_chroma_ds_scheduler.sv - self-checking bench for chroma_ds_scheduler
module tb_chroma_ds_scheduler;

  logic        Clock = 1'b0;
  logic        reset;
  logic [15:0] blk_count;
  logic        timeout_err;

  always #5 Clock = ~Clock;

  chroma_ds_scheduler_if bus ();

  chroma_ds_scheduler #(.TIMEOUT(64)) dut (
    .Clock       (Clock),
    .reset       (reset),
    .bus         (bus.slave),
    .blk_count   (blk_count),
    .timeout_err (timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int clr_cnt = 0;
  int en_cnt = 0;
  int done_lat = 18;
  bit done_en = 1'b1;
  int run_cnt = 0;

  logic [511:0] exp_cb_q[$];
  logic [511:0] exp_cr_q[$];

  function automatic logic [511:0] fill(input logic [7:0] v);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [511:0] quad(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
    logic [511:0] r;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        r[(y*8+x)*8 +: 8] = (y % 2 == 0) ? ((x % 2 == 0) ? a : b) : ((x % 2 == 0) ? c : d);
    return r;
  endfunction

  // Downsampler reference: floor average of each 2x2 quad, replicated into the quad.
  function automatic logic [511:0] ds_model(input logic [511:0] px);
    logic [511:0] r;
    logic [9:0]   s;
    for (int y = 0; y < 8; y += 2)
      for (int x = 0; x < 8; x += 2) begin
        s = 10'(px[(y*8+x)*8 +: 8]) + 10'(px[(y*8+x+1)*8 +: 8])
          + 10'(px[((y+1)*8+x)*8 +: 8]) + 10'(px[((y+1)*8+x+1)*8 +: 8]);
        r[(y*8+x)*8 +: 8]       = s[9:2];
        r[(y*8+x+1)*8 +: 8]     = s[9:2];
        r[((y+1)*8+x)*8 +: 8]   = s[9:2];
        r[((y+1)*8+x+1)*8 +: 8] = s[9:2];
      end
    return r;
  endfunction

  always @(posedge Clock) begin
    if (bus.ds_clear === 1'b1) clr_cnt++;
    if (bus.ds_enable === 1'b1) en_cnt++;
  end

  // Downsampler model: done after done_lat enabled cycles.
  always @(negedge Clock) begin
    if (bus.ds_clear === 1'b1) run_cnt = 0;
    if (bus.ds_enable === 1'b1) begin
      run_cnt++;
      bus.ds_done = done_en && (run_cnt == done_lat);
    end else begin
      bus.ds_done = 1'b0;
    end
    bus.ds_Cb_d = ds_model(bus.ds_Cb);
    bus.ds_Cr_d = ds_model(bus.ds_Cr);
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [511:0] cb, input logic [511:0] cr,
                      input logic [511:0] ecb, input logic [511:0] ecr, input bit push);
    bit ok = 1'b0;
    if (push) begin
      exp_cb_q.push_back(ecb);
      exp_cr_q.push_back(ecr);
    end
    bus.in_Cb    = cb;
    bus.in_Cr    = cr;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready === 1'b1) begin
        cyc(1);
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    bus.in_valid = 1'b0;
    chk("accept", 512'(ok), 512'(1));
  endtask

  task automatic wait_out(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      cyc(1);
    end
    chk("out_valid_seen", 512'(seen), 512'(1));
  endtask

  task automatic handshake();
    logic [511:0] ecb, ecr;
    bus.out_ready = 1'b1;
    if (exp_cb_q.size() == 0) begin
      chk("scoreboard_nonempty", 512'(0), 512'(1));
    end else begin
      ecb = exp_cb_q.pop_front();
      ecr = exp_cr_q.pop_front();
      chk("out_Cb", bus.out_Cb, ecb);
      chk("out_Cr", bus.out_Cr, ecr);
    end
    cyc(1);
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 512'(bus.out_valid), 512'(0));
  endtask

  task automatic recv();
    bit seen;
    wait_out(seen);
    if (seen) handshake();
  endtask

  initial begin
    int base_clr, base_en;
    bit seen;
    logic [511:0] snap_cb, snap_cr, a_cb;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_Cb     = '0;
    bus.in_Cr     = '0;
    bus.out_ready = 1'b0;
    cyc(3);
    chk("rst_in_ready", 512'(bus.in_ready), 512'(1));
    chk("rst_ds_clear", 512'(bus.ds_clear), 512'(0));
    chk("rst_ds_enable", 512'(bus.ds_enable), 512'(0));
    chk("rst_out_valid", 512'(bus.out_valid), 512'(0));
    chk("rst_blk_count", 512'(blk_count), 512'(0));
    chk("rst_timeout_err", 512'(timeout_err), 512'(0));
    chk("rst_ds_Cb", bus.ds_Cb, '0);
    chk("rst_out_Cr", bus.out_Cr, '0);
    reset = 1'b0;
    cyc(2);

    // Uniform block, done after 18 RUN cycles.
    base_clr = clr_cnt;
    base_en  = en_cnt;
    send(fill(8'h10), fill(8'h80), fill(8'h10), fill(8'h80), 1'b1);
    recv();
    chk("t1_clear_pulses", 512'(clr_cnt - base_clr), 512'(1));
    chk("t1_run_cycles", 512'(en_cnt - base_en), 512'(18));
    chk("t1_blk_count", 512'(blk_count), 512'(1));

    // 2x2 quad pattern averaged by the downsampler.
    send(quad(8'd1, 8'd2, 8'd3, 8'd4), quad(8'd10, 8'd20, 8'd30, 8'd40),
         fill(8'd2), fill(8'd25), 1'b1);
    recv();
    chk("t2_blk_count", 512'(blk_count), 512'(2));

    // Consumer stall for 10 cycles with a second block pending.
    a_cb = quad(8'd100, 8'd0, 8'd50, 8'd50);
    send(a_cb, fill(8'h44), fill(8'd50), fill(8'h44), 1'b1);
    wait_out(seen);
    snap_cb = bus.out_Cb;
    snap_cr = bus.out_Cr;
    bus.in_Cb    = fill(8'h33);
    bus.in_Cr    = fill(8'h77);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("stall_out_valid", 512'(bus.out_valid), 512'(1));
      chk("stall_out_Cb", bus.out_Cb, snap_cb);
      chk("stall_out_Cr", bus.out_Cr, snap_cr);
      chk("stall_in_ready", 512'(bus.in_ready), 512'(0));
      chk("stall_ds_Cb", bus.ds_Cb, a_cb);
    end
    handshake();
    chk("stall_blk_count", 512'(blk_count), 512'(3));
    chk("stall_idle_ready", 512'(bus.in_ready), 512'(1));
    exp_cb_q.push_back(fill(8'h33));
    exp_cr_q.push_back(fill(8'h77));
    cyc(1);
    bus.in_valid = 1'b0;
    chk("second_accepted", bus.ds_Cb, fill(8'h33));
    recv();
    chk("second_blk_count", 512'(blk_count), 512'(4));

    // Done on the last allowed watchdog cycle: done wins.
    done_lat = 64;
    base_en  = en_cnt;
    send(fill(8'h5A), fill(8'hA5), fill(8'h5A), fill(8'hA5), 1'b1);
    recv();
    chk("edge_run_cycles", 512'(en_cnt - base_en), 512'(64));
    chk("edge_no_timeout", 512'(timeout_err), 512'(0));
    chk("edge_blk_count", 512'(blk_count), 512'(5));

    // Downsampler never finishes: watchdog fires.
    done_en = 1'b0;
    base_en = en_cnt;
    send(fill(8'h01), fill(8'h02), '0, '0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (timeout_err === 1'b1) begin
        seen = 1'b1;
        break;
      end
      chk("to_no_out_valid", 512'(bus.out_valid), 512'(0));
      cyc(1);
    end
    chk("to_flag", 512'(seen), 512'(1));
    chk("to_run_cycles", 512'(en_cnt - base_en), 512'(64));
    chk("to_idle", 512'(bus.in_ready), 512'(1));
    chk("to_ds_enable", 512'(bus.ds_enable), 512'(0));
    chk("to_blk_count", 512'(blk_count), 512'(5));
    done_en  = 1'b1;
    done_lat = 18;
    send(fill(8'hC0), fill(8'h0C), fill(8'hC0), fill(8'h0C), 1'b1);
    recv();
    chk("after_to_blk_count", 512'(blk_count), 512'(6));
    chk("to_sticky", 512'(timeout_err), 512'(1));

    // Reset in the middle of RUN aborts the block.
    send(fill(8'hEE), fill(8'hDD), '0, '0, 1'b0);
    cyc(5);
    chk("mid_run_enable", 512'(bus.ds_enable), 512'(1));
    #2 reset = 1'b1;
    #1;
    chk("ar_in_ready", 512'(bus.in_ready), 512'(1));
    chk("ar_ds_clear", 512'(bus.ds_clear), 512'(0));
    chk("ar_ds_enable", 512'(bus.ds_enable), 512'(0));
    chk("ar_ds_Cb", bus.ds_Cb, '0);
    chk("ar_ds_Cr", bus.ds_Cr, '0);
    chk("ar_out_Cb", bus.out_Cb, '0);
    chk("ar_out_Cr", bus.out_Cr, '0);
    chk("ar_out_valid", 512'(bus.out_valid), 512'(0));
    chk("ar_blk_count", 512'(blk_count), 512'(0));
    chk("ar_timeout_err", 512'(timeout_err), 512'(0));
    #3 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    chk("ar_no_output", 512'(seen), 512'(0));

    // Counter wrap from 16'hFFFF.
    force dut.blk_count_q = 16'hFFFF;
    cyc(1);
    release dut.blk_count_q;
    cyc(1);
    chk("wrap_preload", 512'(blk_count), 512'(16'hFFFF));
    send(fill(8'h66), fill(8'h99), fill(8'h66), fill(8'h99), 1'b1);
    recv();
    chk("wrap_blk_count", 512'(blk_count), 512'(0));
    chk("scoreboard_empty", 512'(exp_cb_q.size()), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
